// File: rtl/wt_cache_pkg.sv
// ---------------------------------------------------------------------------
// wt_cache_pkg
// Shared definitions for the write-through cache subsystem's invalidation
// path.
//   - inval_line_addr_t : full-width invalidation / snoop address type
//   - WT_INVAL_DEPTH    : default invalidation FIFO depth
//   - wt_line_align()   : clears the byte-offset bits of an address so that
//                         it names a whole cache line
// ---------------------------------------------------------------------------
package wt_cache_pkg;

    localparam int unsigned WT_INVAL_ADDR_W = 64;
    localparam int unsigned WT_INVAL_DEPTH  = 8;

    typedef logic [WT_INVAL_ADDR_W-1:0] inval_line_addr_t;

    // Forces the low offset_w bits to zero. The mask is built by shifting an
    // all-ones value, so offset_w = 0 leaves the address untouched.
    function automatic inval_line_addr_t wt_line_align(
        input inval_line_addr_t addr,
        input int unsigned      offset_w
    );
        inval_line_addr_t mask;
        mask = '1;
        mask = mask << offset_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/wt_inval_fifo.sv
// ---------------------------------------------------------------------------
// wt_inval_fifo
// Depth-entry FIFO of line addresses with a parallel compare of every
// occupied entry against cmp_addr_i.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_addr_i at the tail (ignored when full)
//   push_addr_i     line address to enqueue
//   pop_i           drop the head entry (ignored when empty)
//   cmp_addr_i      line address compared against all occupied entries
//   head_pop_i      the head is leaving this cycle; exclude it from matching
//   match_o         some occupied, non-excluded entry equals cmp_addr_i
//   head_addr_o     address of the head entry
//   full_o          Depth entries occupied
//   empty_o         no entries occupied
// ---------------------------------------------------------------------------
module wt_inval_fifo
    import wt_cache_pkg::*;
#(
    parameter int unsigned AddrWidth = WT_INVAL_ADDR_W,
    parameter int unsigned Depth     = WT_INVAL_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [AddrWidth-1:0] push_addr_i,
    input  logic                 pop_i,
    input  logic [AddrWidth-1:0] cmp_addr_i,
    input  logic                 head_pop_i,
    output logic                 match_o,
    output logic [AddrWidth-1:0] head_addr_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    logic [PtrW:0]          wr_ptr;
    logic [PtrW:0]          rd_ptr;
    logic [PtrW:0]          count;
    logic [AddrWidth-1:0]   mem [Depth];
    logic [Depth-1:0]       match_vec;
    logic                   do_push;
    logic                   do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full_o  = (count == (PtrW+1)'(Depth));
    assign empty_o = (wr_ptr == rd_ptr);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_addr_o = mem[rd_ptr[PtrW-1:0]];

    // A slot is occupied when its distance from the read pointer (modulo
    // Depth) is below the occupancy. Distance zero is the head, which is
    // masked while it is handshaking so a racing snoop gets its own entry.
    for (genvar g = 0; g < Depth; g++) begin : g_slot
        logic [PtrW-1:0] rel;
        assign rel = PtrW'(g) - rd_ptr[PtrW-1:0];
        assign match_vec[g] = ({1'b0, rel} < count)
                           && !(head_pop_i && (rel == '0))
                           && (mem[g] == cmp_addr_i);
    end

    assign match_o = |match_vec;

    // Pointer update: push and pop are independent, so a simultaneous push
    // and pop leaves the occupancy unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr[PtrW-1:0]] <= push_addr_i;
        end
    end

endmodule

// File: rtl/wt_inval_issuer.sv
// ---------------------------------------------------------------------------
// wt_inval_issuer
// Memory-side initiator of the invalidation interface. Store addresses seen
// by the coherent bus monitor are line-aligned, merged against queued
// entries, buffered and issued one at a time on inval_valid_o/inval_ready_i.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   enable_i         1: issue invalidations, 0: accept and discard snoops
//   snoop_valid_i    monitored write address valid
//   snoop_addr_i     monitored write byte address
//   snoop_ready_o    snoop accepted when valid & ready (= !full)
//   inval_valid_o    invalidation request valid (FIFO non-empty)
//   inval_addr_o     line-aligned invalidation address (head entry)
//   inval_ready_i    cache subsystem accepts invalidation
//   empty_o          FIFO empty, no request pending
//   issued_cnt_o     saturating count of handshaken invalidations
//   merged_cnt_o     saturating count of snoops merged into queued entries
//
// Build option: define WT_INVAL_STATS_EN to build the two statistics
// counters; otherwise both counter ports are tied to zero.
// ---------------------------------------------------------------------------
module wt_inval_issuer
    import wt_cache_pkg::*;
#(
    parameter int unsigned AddrWidth       = WT_INVAL_ADDR_W,
    parameter int unsigned LineOffsetWidth = 4,
    parameter int unsigned Depth           = WT_INVAL_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 snoop_valid_i,
    input  logic [AddrWidth-1:0] snoop_addr_i,
    output logic                 snoop_ready_o,
    output logic                 inval_valid_o,
    output logic [AddrWidth-1:0] inval_addr_o,
    input  logic                 inval_ready_i,
    output logic                 empty_o,
    output logic [31:0]          issued_cnt_o,
    output logic [31:0]          merged_cnt_o
);

    logic [AddrWidth-1:0] line_addr;
    logic [AddrWidth-1:0] head_addr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_match;
    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 merge;

    assign line_addr = AddrWidth'(wt_line_align(inval_line_addr_t'(snoop_addr_i),
                                                LineOffsetWidth));

    // Ready depends on registered occupancy only: a pop in the same cycle
    // never frees a slot early, keeping inval_ready_i off the snoop path.
    assign snoop_ready_o = !fifo_full;
    assign accept        = snoop_valid_i && snoop_ready_o;

    assign inval_valid_o = !fifo_empty;
    assign inval_addr_o  = fifo_empty ? '0 : head_addr;
    assign empty_o       = fifo_empty;
    assign pop           = inval_valid_o && inval_ready_i;

    // With enable_i low the snoop is consumed but neither merged nor queued.
    assign merge = accept && enable_i && fifo_match;
    assign push  = accept && enable_i && !fifo_match;

    wt_inval_fifo #(
        .AddrWidth (AddrWidth),
        .Depth     (Depth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_addr_i (line_addr),
        .pop_i       (pop),
        .cmp_addr_i  (line_addr),
        .head_pop_i  (pop),
        .match_o     (fifo_match),
        .head_addr_o (head_addr),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef WT_INVAL_STATS_EN
    logic [31:0] issued_cnt_q;
    logic [31:0] merged_cnt_q;

    // Statistics counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_cnt_q <= '0;
            merged_cnt_q <= '0;
        end else begin
            if (pop && (issued_cnt_q != '1)) begin
                issued_cnt_q <= issued_cnt_q + 32'd1;
            end
            if (merge && (merged_cnt_q != '1)) begin
                merged_cnt_q <= merged_cnt_q + 32'd1;
            end
        end
    end

    assign issued_cnt_o = issued_cnt_q;
    assign merged_cnt_o = merged_cnt_q;
`else
    assign issued_cnt_o = '0;
    assign merged_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wt_inval_issuer.sv
// ---------------------------------------------------------------------------
// tb_wt_inval_issuer
// Directed bench for wt_inval_issuer. A queue-based model tracks what must
// be pending; a compare process checks all outputs every falling edge, and
// the directed sequence adds hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_wt_inval_issuer;

`ifdef WT_INVAL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        snoop_valid;
    logic [63:0] snoop_addr;
    logic        snoop_ready;
    logic        inval_valid;
    logic [63:0] inval_addr;
    logic        inval_ready;
    logic        empty;
    logic [31:0] issued_cnt;
    logic [31:0] merged_cnt;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    // Model state: pending line addresses in issue order plus counters.
    logic [63:0] m_q[$];
    int unsigned m_issued = 0;
    int unsigned m_merged = 0;

    wt_inval_issuer #(
        .AddrWidth       (64),
        .LineOffsetWidth (4),
        .Depth           (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .snoop_valid_i (snoop_valid),
        .snoop_addr_i  (snoop_addr),
        .snoop_ready_o (snoop_ready),
        .inval_valid_o (inval_valid),
        .inval_addr_o  (inval_addr),
        .inval_ready_i (inval_ready),
        .empty_o       (empty),
        .issued_cnt_o  (issued_cnt),
        .merged_cnt_o  (merged_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] a,
                                 input logic rdy, input logic en);
        snoop_valid = v;
        snoop_addr  = a;
        inval_ready = rdy;
        enable      = en;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drainAll();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        for (int i = 0; i < 20 && !empty; i++) begin
            step();
        end
        @(negedge clk);
        checkOutput("drain_empty", {63'd0, empty}, 64'd1);
    endtask

    // Behavioural model: snoops are judged against the queue as it stood
    // before the edge; the head is not a merge target while it is leaving.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_issued = 0;
                m_merged = 0;
            end else begin
                bit          do_pop;
                bit          do_push;
                logic [63:0] line;
                do_pop  = (m_q.size() > 0) && inval_ready;
                do_push = 1'b0;
                line    = snoop_addr & ~64'hF;
                if (snoop_valid && (m_q.size() < DEPTH) && enable) begin
                    bit found;
                    found = 1'b0;
                    for (int i = (do_pop ? 1 : 0); i < m_q.size(); i++) begin
                        if (m_q[i] == line) found = 1'b1;
                    end
                    if (found) begin
                        if (m_merged != 32'hFFFF_FFFF) m_merged++;
                    end else begin
                        do_push = 1'b1;
                    end
                end
                if (do_pop) begin
                    void'(m_q.pop_front());
                    if (m_issued != 32'hFFFF_FFFF) m_issued++;
                end
                if (do_push) m_q.push_back(line);
            end
        end
    end

    // Every falling edge, all outputs are compared against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                checkOutput("m_ready", {63'd0, snoop_ready}, {63'd0, m_q.size() < DEPTH});
                checkOutput("m_valid", {63'd0, inval_valid}, {63'd0, m_q.size() > 0});
                checkOutput("m_empty", {63'd0, empty}, {63'd0, m_q.size() == 0});
                checkOutput("m_addr", inval_addr, (m_q.size() > 0) ? m_q[0] : 64'h0);
                checkOutput("m_issued", {32'd0, issued_cnt}, STATS ? 64'(m_issued) : 64'd0);
                checkOutput("m_merged", {32'd0, merged_cnt}, STATS ? 64'(m_merged) : 64'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        cmp_on = 1'b1;
        step();
        step();
        @(negedge clk);
        checkOutput("rst_ready", {63'd0, snoop_ready}, 64'd1);
        checkOutput("rst_valid", {63'd0, inval_valid}, 64'd0);
        checkOutput("rst_empty", {63'd0, empty}, 64'd1);
        checkOutput("rst_addr", inval_addr, 64'h0);
        step();
        rst_n = 1'b1;

        // Single snoop: visible the cycle after push, gone the cycle after.
        applyStimulus(1'b1, 64'h8000_1237, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("single_valid", {63'd0, inval_valid}, 64'd1);
        checkOutput("single_addr", inval_addr, 64'h8000_1230);
        step();
        @(negedge clk);
        checkOutput("single_empty", {63'd0, empty}, 64'd1);
        checkOutput("single_issued", {32'd0, issued_cnt}, STATS ? 64'd1 : 64'd0);

        // Merge: 0x10C folds into 0x100.
        applyStimulus(1'b1, 64'h100, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 64'h10C, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 64'h200, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("merge_head0", inval_addr, 64'h100);
        checkOutput("merge_cnt", {32'd0, merged_cnt}, STATS ? 64'd1 : 64'd0);
        step();
        @(negedge clk);
        checkOutput("merge_head1", inval_addr, 64'h200);
        step();
        @(negedge clk);
        checkOutput("merge_empty", {63'd0, empty}, 64'd1);

        // Backpressure: eight distinct lines fill the FIFO, ninth is held.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 64'h1000 + 64'(i * 16) + 64'h3, 1'b0, 1'b1);
            step();
        end
        applyStimulus(1'b1, 64'h1083, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("full_ready", {63'd0, snoop_ready}, 64'd0);
        checkOutput("full_head", inval_addr, 64'h1000);
        step();
        step();
        @(negedge clk);
        checkOutput("stall_ready", {63'd0, snoop_ready}, 64'd0);
        checkOutput("stall_head", inval_addr, 64'h1000);
        applyStimulus(1'b1, 64'h1083, 1'b1, 1'b1);
        step();
        @(negedge clk);
        checkOutput("pop_frees_ready", {63'd0, snoop_ready}, 64'd1);
        checkOutput("pop_head", inval_addr, 64'h1010);
        applyStimulus(1'b1, 64'h1083, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("refull_ready", {63'd0, snoop_ready}, 64'd0);
        drainAll();

        // Head-pop race: 0x304 arrives while 0x300 handshakes.
        applyStimulus(1'b1, 64'h300, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 64'h304, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("race_valid", {63'd0, inval_valid}, 64'd1);
        checkOutput("race_addr", inval_addr, 64'h300);
        checkOutput("race_merged", {32'd0, merged_cnt}, STATS ? 64'd1 : 64'd0);
        step();
        @(negedge clk);
        checkOutput("race_empty", {63'd0, empty}, 64'd1);
        checkOutput("race_issued", {32'd0, issued_cnt}, STATS ? 64'd14 : 64'd0);

        // Disabled: snoops accepted and dropped.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'h4000 + 64'(i * 64), 1'b0, 1'b0);
            step();
            @(negedge clk);
            checkOutput("dis_ready", {63'd0, snoop_ready}, 64'd1);
            checkOutput("dis_empty", {63'd0, empty}, 64'd1);
        end

        // Reset mid-operation with five entries queued.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 64'h5000 + 64'(i * 16), 1'b0, 1'b1);
            step();
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("pre_rst_head", inval_addr, 64'h5000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {63'd0, inval_valid}, 64'd0);
        checkOutput("mid_rst_ready", {63'd0, snoop_ready}, 64'd1);
        checkOutput("mid_rst_issued", {32'd0, issued_cnt}, 64'd0);
        checkOutput("mid_rst_merged", {32'd0, merged_cnt}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checkOutput("post_rst_empty", {63'd0, empty}, 64'd1);

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wt_inval_issuer.md
Name: wt_inval_issuer

Overview:
- Memory-side initiator of the write-through cache subsystem's invalidation interface (inval_addr/inval_valid/inval_ready).
- Accepts store-address observations from a coherent bus monitor (other masters' writes).
- Converts each to a line-aligned address, merges duplicates, buffers them, and issues them one at a time to the cache subsystem with a valid/ready handshake.

Parameters:
- AddrWidth, 64, width of snoop and invalidation addresses.
- LineOffsetWidth, 4, byte-offset bits cleared for line alignment (16-byte D$ line).
- Depth, 8, invalidation FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  1: issue invalidations; 0: accept and discard snoops
- snoop_valid_i  in  1  monitored write address valid
- snoop_addr_i  in  AddrWidth  monitored write byte address
- snoop_ready_o  out  1  snoop accepted this cycle when valid&ready
- inval_valid_o  out  1  invalidation request valid
- inval_addr_o  out  AddrWidth  line-aligned invalidation address
- inval_ready_i  in  1  cache subsystem accepts invalidation
- empty_o  out  1  FIFO empty and no request pending
- issued_cnt_o  out  32  invalidations handshaken (stats)
- merged_cnt_o  out  32  snoops merged into existing entries (stats)

Behaviour:
- Reset (asynchronous, rst_ni low): FIFO empty, pointers 0; snoop_ready_o=1, inval_valid_o=0, inval_addr_o=0, empty_o=1, both counters 0.
- Line address: snoop_addr_i with the low LineOffsetWidth bits forced to 0.
- snoop_ready_o = !full, registered-state only; no combinational path from inval_ready_i.
  - Full means Depth entries occupied. A push is refused when full, even if a pop happens in the same cycle.
- Accept (snoop_valid_i & snoop_ready_o & enable_i), three cases:
  - Line matches a valid entry that is not being popped this cycle: merged, no push, merged_cnt +1.
  - Line matches the head entry that is handshaking this cycle: pushed as a new entry (conservative, never merged).
  - No match: pushed at the tail.
- enable_i=0: snoops are still accepted (ready follows !full) but discarded. Entries already queued keep draining.
- Output: inval_valid_o = FIFO non-empty; inval_addr_o = head entry.
  - Latency: a snoop pushed into an empty FIFO in cycle N appears on inval_valid_o in cycle N+1.
  - Once inval_valid_o is high, inval_valid_o and inval_addr_o stay stable until inval_ready_i=1.
  - Handshake pops the head and increments issued_cnt by 1; back-to-back pops at one per cycle.
- Simultaneous push and pop (not full): both occur and occupancy is unchanged.
- Pointer wrap: Depth is a power of two; pointers carry one extra bit to distinguish full from empty.
- empty_o = FIFO empty (combinational from state).
- Counters saturate at 0xFFFF_FFFF.
- Reset asserted mid-operation: all queued invalidations are lost. Consumers re-flush after reset.

Optional Feature:
- Macro WT_INVAL_STATS_EN.
  - Defined: issued_cnt_o and merged_cnt_o are live saturating counters as above.
  - Undefined: counter flops are not built and both ports are tied to 0. Port list is unchanged.

Decomposition:
- Shared package wt_cache_pkg:
  - inval_line_addr_t typedef (AddrWidth).
  - Line-alignment function.
  - WT_INVAL_DEPTH default constant.
- Sub-module wt_inval_fifo:
  - Depth-entry FIFO with a parallel line-address compare (match vector).
  - Head-pop exclusion input.
  - full/empty outputs.
- The top level holds the handshake glue and the counters.

Test Plan:
- Single snoop: snoop_addr 0x8000_1237 in cycle 0, inval_ready_i=1 -> inval_addr_o=0x8000_1230 valid in cycle 1, issued_cnt=1, empty_o=1 in cycle 2.
- Merge: with inval_ready_i=0, snoops 0x100, 0x10C, 0x200 -> two entries (0x100, 0x200), merged_cnt=1. Release ready -> issued in that order.
- Backpressure/full: Depth=8, inval_ready_i=0, 9 distinct lines -> snoop_ready_o=0 after the 8th. The 9th is held until one pop, then accepted. inval_addr_o is stable while stalled.
- Head-pop race: head=0x300 handshaking while snoop 0x304 arrives -> 0x300 pushed again; two 0x300 invalidations issued, merged_cnt unchanged.
- enable_i=0: 4 snoops -> all accepted, no inval_valid_o, empty_o stays 1.
- Reset mid-operation: 5 entries queued, rst_ni low for 1 cycle -> inval_valid_o=0 immediately, counters 0, snoop_ready_o=1. With WT_INVAL_STATS_EN undefined, counters read 0 throughout.
